// File: rtl/hpdcache_flush_walker_pkg.sv
// Shared configuration for the flush-all walker slice: the cache geometry
// record consumed by the walker and a helper for the cacheline index width.
package hpdcache_flush_walker_pkg;

    typedef struct packed {
        struct packed {
            int unsigned sets;
            int unsigned ways;
        } u;
        int unsigned setWidth;
        int unsigned tagWidth;
    } hpdcache_cfg_t;

    // Geometry used when the instantiating controller does not override it.
    localparam hpdcache_cfg_t HPDCACHE_DEFAULT_CFG = '{
        u:        '{sets: 64, ways: 4},
        setWidth: 6,
        tagWidth: 8
    };

    // A cacheline index is the tag concatenated above the set index.
    function automatic int unsigned hpdcacheNlineWidth(input hpdcache_cfg_t cfg);
        return cfg.setWidth + cfg.tagWidth;
    endfunction

endpackage

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Priority one-hot encoder: keeps only the lowest set bit of the input
// vector, so the walker always services the lowest-numbered pending way.
module hpdcache_prio_1hot_encoder
    import hpdcache_flush_walker_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] i_val,
    output logic [N-1:0] o_val
);

    // Two's complement trick: x & -x isolates the least significant one.
    always_comb begin
        o_val = i_val & (~i_val + N'(1));
    end

endmodule

// File: rtl/hpdcache_flush_walker.sv
// Flush-all sequencer: walks every directory set, hands each valid dirty
// line to the flush controller and clears its dirty bit, then waits for the
// flush controller to drain before pulsing completion.
module hpdcache_flush_walker
    import hpdcache_flush_walker_pkg::*;
#(
    parameter hpdcache_cfg_t HPDcacheCfg = HPDCACHE_DEFAULT_CFG,
    parameter type hpdcache_nline_t      = logic [hpdcacheNlineWidth(HPDcacheCfg)-1:0],
    parameter type hpdcache_set_t        = logic [HPDcacheCfg.setWidth-1:0],
    parameter type hpdcache_tag_t        = logic [HPDcacheCfg.tagWidth-1:0],
    parameter type hpdcache_way_vector_t = logic [HPDcacheCfg.u.ways-1:0]
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 start_i,
    output logic                 start_ready_o,
    output logic                 busy_o,
    output logic                 done_o,

    output logic                 dir_req_o,
    input  logic                 dir_gnt_i,
    output logic                 dir_rd_o,
    output hpdcache_set_t        dir_set_o,
    input  hpdcache_way_vector_t dir_rd_valid_i,
    input  hpdcache_way_vector_t dir_rd_dirty_i,
    input  logic [HPDcacheCfg.u.ways*HPDcacheCfg.tagWidth-1:0] dir_rd_tag_i,
    output logic                 dir_clean_o,
    output hpdcache_way_vector_t dir_clean_way_o,

    output logic                 flush_alloc_o,
    input  logic                 flush_alloc_ready_i,
    output hpdcache_nline_t      flush_alloc_nline_o,
    output hpdcache_way_vector_t flush_alloc_way_o,
    input  logic                 flush_empty_i
);

    localparam int Ways = int'(HPDcacheCfg.u.ways);
    localparam int TagW = int'(HPDcacheCfg.tagWidth);
    localparam int Sets = int'(HPDcacheCfg.u.sets);

    // The walk stops after this set; the set counter never wraps.
    localparam hpdcache_set_t LastSet = hpdcache_set_t'(Sets - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SCAN,
        DRAIN
    } state_e;

    state_e                      r_state;
    state_e                      w_stateNext;

    hpdcache_set_t               r_setQ;
    hpdcache_way_vector_t        r_maskQ;
    logic [Ways*TagW-1:0]        r_tagsQ;

    hpdcache_way_vector_t        w_waySel;
    hpdcache_tag_t               w_selTag;
    logic                        w_setClear;
    logic                        w_setInc;
    logic                        w_latch;
    logic                        w_wayDone;

    hpdcache_prio_1hot_encoder #(
        .N (Ways)
    ) u_waySelect (
        .i_val (r_maskQ),
        .o_val (w_waySel)
    );

    // Pick the tag of the selected way out of the latched tag vector.
    always_comb begin
        w_selTag = '0;
        for (int w = 0; w < Ways; w++) begin
            if (w_waySel[w]) begin
                w_selTag = w_selTag | r_tagsQ[w*TagW +: TagW];
            end
        end
    end

    // State register; reset abandons any partial walk without completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake decode for the walk.
    always_comb begin
        w_stateNext   = r_state;
        start_ready_o = 1'b0;
        busy_o        = 1'b1;
        done_o        = 1'b0;
        dir_req_o     = 1'b0;
        dir_rd_o      = 1'b0;
        dir_clean_o   = 1'b0;
        flush_alloc_o = 1'b0;
        w_setClear    = 1'b0;
        w_setInc      = 1'b0;
        w_latch       = 1'b0;
        w_wayDone     = 1'b0;

        unique case (r_state)
            IDLE: begin
                start_ready_o = 1'b1;
                busy_o        = 1'b0;
                if (start_i) begin
                    w_setClear  = 1'b1;
                    w_stateNext = READ;
                end
            end

            READ: begin
                dir_req_o = 1'b1;
                dir_rd_o  = 1'b1;
                if (dir_gnt_i) begin
                    w_stateNext = LATCH;
                end
            end

            LATCH: begin
                w_latch     = 1'b1;
                w_stateNext = SCAN;
            end

            SCAN: begin
                if (r_maskQ != '0) begin
                    // The alloc and the dirty-bit clean complete together,
                    // and both need the directory port.
                    dir_req_o     = 1'b1;
                    flush_alloc_o = dir_gnt_i;
                    if (dir_gnt_i && flush_alloc_ready_i) begin
                        dir_clean_o = 1'b1;
                        w_wayDone   = 1'b1;
                    end
                end else if (r_setQ == LastSet) begin
                    w_stateNext = DRAIN;
                end else begin
                    w_setInc    = 1'b1;
                    w_stateNext = READ;
                end
            end

            DRAIN: begin
                if (flush_empty_i) begin
                    done_o      = 1'b1;
                    w_stateNext = IDLE;
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Set counter, pending-way mask and latched tags of the current set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_setQ  <= '0;
            r_maskQ <= '0;
            r_tagsQ <= '0;
        end else begin
            if (w_setClear) begin
                r_setQ <= '0;
            end else if (w_setInc) begin
                r_setQ <= r_setQ + hpdcache_set_t'(1);
            end

            if (w_latch) begin
                r_maskQ <= dir_rd_valid_i & dir_rd_dirty_i;
                r_tagsQ <= dir_rd_tag_i;
            end else if (w_wayDone) begin
                r_maskQ <= r_maskQ & ~w_waySel;
            end
        end
    end

    assign dir_set_o           = r_setQ;
    assign dir_clean_way_o     = dir_clean_o ? w_waySel : '0;
    assign flush_alloc_way_o   = w_waySel;
    assign flush_alloc_nline_o = {w_selTag, r_setQ};

endmodule

// File: tb/tb_hpdcache_flush_walker.sv
// Testbench for the flush-all walker: a behavioural directory answers reads
// and applies cleans, and a table of scenarios drives grant, ready and empty
// patterns against hand-computed completion cycles and alloc sequences.
module tb_hpdcache_flush_walker;
   import hpdcache_flush_walker_pkg::*;

   localparam hpdcache_cfg_t Cfg = '{u: '{sets: 64, ways: 4}, setWidth: 6, tagWidth: 8};

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic        start_ready_o;
   logic        busy_o;
   logic        done_o;
   logic        dir_req_o;
   logic        dir_gnt_i;
   logic        dir_rd_o;
   logic [5:0]  dir_set_o;
   logic [3:0]  dir_rd_valid_i;
   logic [3:0]  dir_rd_dirty_i;
   logic [31:0] dir_rd_tag_i;
   logic        dir_clean_o;
   logic [3:0]  dir_clean_way_o;
   logic        flush_alloc_o;
   logic        flush_alloc_ready_i;
   logic [13:0] flush_alloc_nline_o;
   logic [3:0]  flush_alloc_way_o;
   logic        flush_empty_i;

   hpdcache_flush_walker #(
      .HPDcacheCfg (Cfg)
   ) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .start_i             (start_i),
      .start_ready_o       (start_ready_o),
      .busy_o              (busy_o),
      .done_o              (done_o),
      .dir_req_o           (dir_req_o),
      .dir_gnt_i           (dir_gnt_i),
      .dir_rd_o            (dir_rd_o),
      .dir_set_o           (dir_set_o),
      .dir_rd_valid_i      (dir_rd_valid_i),
      .dir_rd_dirty_i      (dir_rd_dirty_i),
      .dir_rd_tag_i        (dir_rd_tag_i),
      .dir_clean_o         (dir_clean_o),
      .dir_clean_way_o     (dir_clean_way_o),
      .flush_alloc_o       (flush_alloc_o),
      .flush_alloc_ready_i (flush_alloc_ready_i),
      .flush_alloc_nline_o (flush_alloc_nline_o),
      .flush_alloc_way_o   (flush_alloc_way_o),
      .flush_empty_i       (flush_empty_i)
   );

   always #5 clk_i = ~clk_i;

   // One scenario: directory contents, input patterns, expected results.
   typedef struct {
      int contents;
      int gntMode;
      int readyLowFrom;
      int readyLowLen;
      int emptyLowFrom;
      int emptyLowLen;
      int startAgainAt;
      int expAllocs;
      int expDone;
   } scen_t;

   scen_t       table_q[5];
   scen_t       cur;

   logic [3:0]  mValid [64];
   logic [3:0]  mDirty [64];
   logic [7:0]  mTag   [64][4];

   logic [13:0] expNline [2];
   logic [3:0]  expWay   [2];
   logic [13:0] actNline [$];
   logic [3:0]  actWay   [$];

   int          checks = 0;
   int          failures = 0;
   int          cycleNo;
   int          doneCycle;
   int          doneCount;
   int          busyErr;
   int          protoErr;
   int          stabErr;
   int          stallSeen;
   int          readCount;
   logic        prevStall;
   logic [13:0] prevNline;
   logic [3:0]  prevWay;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Fill the behavioural directory for a scenario.
   task automatic loadContents(input int kind);
      for (int s = 0; s < 64; s++) begin
         mValid[s] = 4'($urandom);
         mDirty[s] = 4'b0000;
         for (int w = 0; w < 4; w++) mTag[s][w] = 8'($urandom);
      end
      if (kind == 1) begin
         mValid[5] = 4'b0111;
         mDirty[5] = 4'b1101;
         mTag[5][0] = 8'h12;
         mTag[5][1] = 8'h55;
         mTag[5][2] = 8'h34;
         mTag[5][3] = 8'h77;
         mValid[9] = 4'b1000;
         mDirty[9] = 4'b0010;
      end
   endtask

   // Drive grant, ready and empty for the current cycle.
   task automatic setInputs();
      dir_gnt_i = (cur.gntMode == 0) || (cycleNo % 3 == 0);
      flush_alloc_ready_i = !(cur.readyLowFrom >= 0 && cycleNo >= cur.readyLowFrom &&
                              cycleNo < cur.readyLowFrom + cur.readyLowLen);
      flush_empty_i = !(cur.emptyLowFrom >= 0 && cycleNo >= cur.emptyLowFrom &&
                        cycleNo < cur.emptyLowFrom + cur.emptyLowLen);
   endtask

   // Sample outputs mid-cycle, then advance one clock and play the directory.
   task automatic cycle();
      logic       hs;
      logic       rdReq;
      logic [5:0] setSample;
      logic [3:0] hsWay;
      logic       expBusy;
      @(negedge clk_i);
      hs = flush_alloc_o & flush_alloc_ready_i;
      rdReq = dir_req_o & dir_rd_o & dir_gnt_i;
      setSample = dir_set_o;
      hsWay = flush_alloc_way_o;
      if (done_o === 1'b1) begin
         doneCount++;
         if (doneCycle < 0) doneCycle = cycleNo;
      end
      expBusy = (cycleNo >= 1) && (doneCycle < 0 || cycleNo <= doneCycle);
      if (busy_o !== expBusy) busyErr++;
      if (cycleNo == cur.startAgainAt) checkOutput("start_ready_while_busy", 32'(start_ready_o), 32'd0);
      if (dir_clean_o !== hs) protoErr++;
      if (hs) begin
         if (dir_clean_way_o !== flush_alloc_way_o || dir_set_o !== flush_alloc_nline_o[5:0]) protoErr++;
         actNline.push_back(flush_alloc_nline_o);
         actWay.push_back(flush_alloc_way_o);
      end
      if (flush_alloc_o && !dir_req_o) protoErr++;
      if (rdReq) begin
         if (setSample !== 6'(readCount)) protoErr++;
         readCount++;
      end
      if (cur.gntMode == 0 && prevStall &&
          (flush_alloc_o !== 1'b1 || flush_alloc_nline_o !== prevNline || flush_alloc_way_o !== prevWay))
         stabErr++;
      prevStall = flush_alloc_o & ~flush_alloc_ready_i;
      if (prevStall) stallSeen++;
      prevNline = flush_alloc_nline_o;
      prevWay = flush_alloc_way_o;
      @(posedge clk_i);
      #1;
      if (hs) begin
         for (int w = 0; w < 4; w++) if (hsWay[w]) mDirty[setSample][w] = 1'b0;
      end
      if (rdReq) begin
         dir_rd_valid_i = mValid[setSample];
         dir_rd_dirty_i = mDirty[setSample];
         for (int w = 0; w < 4; w++) dir_rd_tag_i[w*8 +: 8] = mTag[setSample][w];
      end else begin
         dir_rd_valid_i = 4'($urandom);
         dir_rd_dirty_i = 4'($urandom);
         dir_rd_tag_i = $urandom;
      end
      cycleNo++;
      start_i = (cycleNo == cur.startAgainAt);
      setInputs();
   endtask

   // Apply reset, confirm the reset state, release reset.
   task automatic doReset();
      rst_ni = 1'b0;
      start_i = 1'b0;
      dir_gnt_i = 1'b1;
      flush_alloc_ready_i = 1'b1;
      flush_empty_i = 1'b1;
      dir_rd_valid_i = '0;
      dir_rd_dirty_i = '0;
      dir_rd_tag_i = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("reset_state",
                  32'({start_ready_o, busy_o, done_o, dir_req_o, dir_rd_o, dir_clean_o, flush_alloc_o}),
                  32'b1000000);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic clearCounters();
      cycleNo = 0;
      doneCycle = -1;
      doneCount = 0;
      busyErr = 0;
      protoErr = 0;
      stabErr = 0;
      stallSeen = 0;
      readCount = 0;
      prevStall = 1'b0;
      prevNline = '0;
      prevWay = '0;
      actNline.delete();
      actWay.delete();
   endtask

   // Run one table scenario from start to completion and score it.
   task automatic applyStimulus(input int idx);
      cur = table_q[idx];
      doReset();
      loadContents(cur.contents);
      clearCounters();
      start_i = 1'b1;
      setInputs();
      while (cycleNo < 1000 && !(doneCycle >= 0 && cycleNo > doneCycle + 3)) cycle();
      checkOutput($sformatf("s%0d_done_count", idx), 32'(doneCount), 32'd1);
      if (cur.expDone >= 0)
         checkOutput($sformatf("s%0d_done_cycle", idx), 32'(doneCycle), 32'(cur.expDone));
      checkOutput($sformatf("s%0d_busy_errors", idx), 32'(busyErr), 32'd0);
      checkOutput($sformatf("s%0d_protocol_errors", idx), 32'(protoErr), 32'd0);
      checkOutput($sformatf("s%0d_stall_stability", idx), 32'(stabErr), 32'd0);
      checkOutput($sformatf("s%0d_stall_cycles", idx), 32'(stallSeen), 32'(cur.readyLowLen));
      checkOutput($sformatf("s%0d_reads", idx), 32'(readCount), 32'd64);
      checkOutput($sformatf("s%0d_alloc_count", idx), 32'(actNline.size()), 32'(cur.expAllocs));
      for (int i = 0; i < cur.expAllocs && i < actNline.size(); i++) begin
         checkOutput($sformatf("s%0d_alloc%0d_nline", idx, i), 32'(actNline[i]), 32'(expNline[i]));
         checkOutput($sformatf("s%0d_alloc%0d_way", idx, i), 32'(actWay[i]), 32'(expWay[i]));
      end
      if (cur.contents == 1)
         checkOutput($sformatf("s%0d_set5_dirty_after", idx), 32'(mDirty[5]), 32'b1000);
   endtask

   initial begin
      // contents, gntMode, readyLowFrom, readyLowLen, emptyLowFrom, emptyLowLen, startAgainAt, expAllocs, expDone
      table_q[0] = '{0, 0, -1,  0,  -1,  0, 50, 0, 193};
      table_q[1] = '{1, 0, -1,  0,  -1,  0, -1, 2, 195};
      table_q[2] = '{1, 1, -1,  0,  -1,  0, -1, 2,  -1};
      table_q[3] = '{1, 0, 18, 10,  -1,  0, -1, 2, 205};
      table_q[4] = '{1, 0, -1,  0, 195, 20, -1, 2, 215};
      expNline[0] = 14'h485;
      expWay[0]   = 4'b0001;
      expNline[1] = 14'hD05;
      expWay[1]   = 4'b0100;

      for (int i = 0; i < 5; i++) applyStimulus(i);

      // Reset while stalled mid-SCAN on set 5: abandon the walk, no completion.
      cur = '{1, 0, 18, 1000, -1, 0, -1, 2, -1};
      doReset();
      loadContents(1);
      clearCounters();
      start_i = 1'b1;
      setInputs();
      while (cycleNo < 22) cycle();
      #1;
      checkOutput("pre_reset_alloc_pending", 32'(flush_alloc_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      checkOutput("mid_scan_reset_outputs",
                  32'({start_ready_o, busy_o, done_o, dir_req_o, dir_rd_o, dir_clean_o, flush_alloc_o}),
                  32'b1000000);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      start_i = 1'b0;
      doneCount = 0;
      repeat (20) cycle();
      checkOutput("post_reset_no_done", 32'(doneCount), 32'd0);
      checkOutput("post_reset_idle", 32'({start_ready_o, busy_o}), 32'b10);
      checkOutput("post_reset_dirty_kept", 32'(mDirty[5]), 32'b1101);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
